// File: rtl/alu_muldiv_seq_if.sv
// Bundle between the mul/div sequencer, its requester and the datapath ALU.
// Slave modport is the sequencer side; master is the requester/ALU side.
interface alu_muldiv_seq_if #(
    parameter int N  = 16,
    parameter int FW = 5,
    parameter int OW = 4
);
    logic          i_w_start;
    logic          i_w_op;
    logic [N-1:0]  i_w_a;
    logic [N-1:0]  i_w_b;
    logic          o_w_busy;
    logic          o_w_done;
    logic          o_w_dbz;
    logic [N-1:0]  o_w_res_hi;
    logic [N-1:0]  o_w_res_lo;
    logic [OW-1:0] o_w_alu_opcode;
    logic [N-1:0]  o_w_alu_in1;
    logic [N-1:0]  o_w_alu_in2;
    logic          o_w_alu_carry;
    logic          o_w_alu_oe;
    logic [N-1:0]  i_w_alu_out;
    logic [FW-1:0] i_w_alu_flags;

    modport slave (
        input  i_w_start, i_w_op, i_w_a, i_w_b,
        input  i_w_alu_out, i_w_alu_flags,
        output o_w_busy, o_w_done, o_w_dbz,
        output o_w_res_hi, o_w_res_lo,
        output o_w_alu_opcode, o_w_alu_in1, o_w_alu_in2,
        output o_w_alu_carry, o_w_alu_oe
    );

    modport master (
        output i_w_start, i_w_op, i_w_a, i_w_b,
        output i_w_alu_out, i_w_alu_flags,
        input  o_w_busy, o_w_done, o_w_dbz,
        input  o_w_res_hi, o_w_res_lo,
        input  o_w_alu_opcode, o_w_alu_in1, o_w_alu_in2,
        input  o_w_alu_carry, o_w_alu_oe
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned shift-add multiply / restoring divide that borrows
// the datapath ALU for its add/subtract steps, one step per clock.
module alu_muldiv_seq #(
    parameter int p_data_width   = 16,
    parameter int p_flags_width  = 5,
    parameter int p_opcode_width = 4,
    parameter logic [p_opcode_width-1:0] p_opcode_ADC  = 4'd0,
    parameter logic [p_opcode_width-1:0] p_opcode_SBB1 = 4'd1
) (
    input  logic              i_w_clk,
    input  logic              i_w_rst_n,
    alu_muldiv_seq_if.slave   bus
);
    localparam int N  = p_data_width;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [N-1:0]        h, h_nxt;
    logic [N-1:0]        l, l_nxt;
    logic [N-1:0]        b, b_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic                dbz, dbz_nxt;

    logic [p_opcode_width-1:0] alu_opcode;
    logic [N-1:0]        alu_in1;
    logic [N-1:0]        alu_in2;
    logic                alu_oe;
    logic                alu_c;
    logic [N-1:0]        t;
    logic                msb;
    logic                flags_unused;

    // Carry (ADC) and borrow (SBB1) both come back on flags[0].
    assign alu_c        = bus.i_w_alu_flags[0];
    assign flags_unused = ^bus.i_w_alu_flags[p_flags_width-1:1];

    // Next-state, datapath update and ALU drive for the current step.
    always_comb begin
        state_nxt  = state;
        h_nxt      = h;
        l_nxt      = l;
        b_nxt      = b;
        cnt_nxt    = cnt;
        dbz_nxt    = dbz;
        alu_opcode = p_opcode_ADC;
        alu_in1    = '0;
        alu_in2    = '0;
        alu_oe     = 1'b0;
        t          = {h[N-2:0], l[N-1]};
        msb        = h[N-1];
        unique case (state)
            S_IDLE, S_DONE: begin
                if (state == S_DONE) state_nxt = S_IDLE;
                if (bus.i_w_start) begin
                    b_nxt   = bus.i_w_b;
                    cnt_nxt = CW'(N);
                    dbz_nxt = 1'b0;
                    h_nxt   = '0;
                    l_nxt   = bus.i_w_a;
                    if (!bus.i_w_op) begin
                        state_nxt = S_MUL;
                    end else if (bus.i_w_b == '0) begin
                        // Divisor zero: all-ones quotient, dividend as remainder.
                        h_nxt     = bus.i_w_a;
                        l_nxt     = '1;
                        dbz_nxt   = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_DIV;
                    end
                end
            end
            S_MUL: begin
                alu_opcode = p_opcode_ADC;
                alu_in1    = h;
                alu_in2    = b;
                alu_oe     = 1'b1;
                if (l[0]) begin
                    h_nxt = {alu_c, bus.i_w_alu_out[N-1:1]};
                    l_nxt = {bus.i_w_alu_out[0], l[N-1:1]};
                end else begin
                    h_nxt = {1'b0, h[N-1:1]};
                    l_nxt = {h[0], l[N-1:1]};
                end
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) state_nxt = S_DONE;
            end
            S_DIV: begin
                alu_opcode = p_opcode_SBB1;
                alu_in1    = t;
                alu_in2    = b;
                alu_oe     = 1'b1;
                // A shifted-out msb means the partial remainder already exceeds B.
                if (msb || !alu_c) begin
                    h_nxt = bus.i_w_alu_out;
                    l_nxt = {l[N-2:0], 1'b1};
                end else begin
                    h_nxt = t;
                    l_nxt = {l[N-2:0], 1'b0};
                end
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State and operand registers.
    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) begin
            state <= S_IDLE;
            h     <= '0;
            l     <= '0;
            b     <= '0;
            cnt   <= '0;
            dbz   <= 1'b0;
        end else begin
            state <= state_nxt;
            h     <= h_nxt;
            l     <= l_nxt;
            b     <= b_nxt;
            cnt   <= cnt_nxt;
            dbz   <= dbz_nxt;
        end
    end

    assign bus.o_w_busy       = (state == S_MUL) || (state == S_DIV);
    assign bus.o_w_done       = (state == S_DONE);
    assign bus.o_w_dbz        = dbz;
    assign bus.o_w_res_hi     = h;
    assign bus.o_w_res_lo     = l;
    assign bus.o_w_alu_opcode = alu_opcode;
    assign bus.o_w_alu_in1    = alu_in1;
    assign bus.o_w_alu_in2    = alu_in2;
    assign bus.o_w_alu_carry  = 1'b0;
    assign bus.o_w_alu_oe     = alu_oe;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: behavioural ALU plus arithmetic reference model,
// directed corner cases and randomized operations.
module tb_alu_muldiv_seq;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq_if #(.N(N), .FW(5), .OW(4)) bus ();

    alu_muldiv_seq dut (
        .i_w_clk   (clk),
        .i_w_rst_n (rst_n),
        .bus       (bus)
    );

    // Behavioural ALU: ADC and SBB1, carry/borrow in flags[0].
    logic [N:0] alu_r;
    always_comb begin
        alu_r = '0;
        if (bus.o_w_alu_opcode == 4'd1)
            alu_r = {1'b0, bus.o_w_alu_in1} - {1'b0, bus.o_w_alu_in2}
                    - (N+1)'(bus.o_w_alu_carry);
        else
            alu_r = {1'b0, bus.o_w_alu_in1} + {1'b0, bus.o_w_alu_in2}
                    + (N+1)'(bus.o_w_alu_carry);
        bus.i_w_alu_out   = alu_r[N-1:0];
        bus.i_w_alu_flags = {^alu_r[N-1:0], alu_r[N-1],
                             alu_r[N-1:0] == '0, 1'b0, alu_r[N]};
    end

    // Reference: plain integer multiply / divide.
    task automatic ref_op(input bit op, input logic [N-1:0] a, input logic [N-1:0] b,
                          output logic [N-1:0] hi, output logic [N-1:0] lo,
                          output logic dz, output int lat);
        logic [2*N-1:0] p;
        p = (2*N)'(a) * (2*N)'(b);
        if (!op) begin
            hi = p[2*N-1:N]; lo = p[N-1:0]; dz = 1'b0; lat = N;
        end else if (b == 0) begin
            hi = a; lo = '1; dz = 1'b1; lat = 0;
        end else begin
            hi = a % b; lo = a / b; dz = 1'b0; lat = N;
        end
    endtask

    // Drive one start from a negedge and wait (bounded) for done.
    // lat = accept-edge-relative edge index at which done became visible.
    task automatic do_op(input bit op, input logic [N-1:0] a, input logic [N-1:0] b,
                         output int lat, output bit alu_ok, output bit busy_ok);
        bus.i_w_start = 1'b1;
        bus.i_w_op    = op;
        bus.i_w_a     = a;
        bus.i_w_b     = b;
        @(negedge clk);
        bus.i_w_start = 1'b0;
        lat = -1; alu_ok = 1'b1; busy_ok = 1'b1;
        for (int k = 0; k < 64; k++) begin
            if (bus.o_w_alu_carry !== 1'b0) alu_ok = 1'b0;
            if (bus.o_w_alu_oe !== bus.o_w_busy) alu_ok = 1'b0;
            if (!bus.o_w_busy && (bus.o_w_alu_opcode !== 4'd0 ||
                bus.o_w_alu_in1 !== '0 || bus.o_w_alu_in2 !== '0)) alu_ok = 1'b0;
            if (bus.o_w_done) begin
                if (bus.o_w_busy) busy_ok = 1'b0;
                lat = k;
                break;
            end
            if (!bus.o_w_busy) busy_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.i_w_start = 1'b0; bus.i_w_op = 1'b0;
        bus.i_w_a = '0; bus.i_w_b = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.o_w_busy !== 1'b0 || bus.o_w_done !== 1'b0 || bus.o_w_dbz !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got busy=%b done=%b dbz=%b required 0 0 0",
                     bus.o_w_busy, bus.o_w_done, bus.o_w_dbz);
        end
        n_tests++;
        if (bus.o_w_res_hi !== '0 || bus.o_w_res_lo !== '0) begin
            n_fail++;
            $display("FAIL reset_res: got %h_%h required 0000_0000",
                     bus.o_w_res_hi, bus.o_w_res_lo);
        end
        n_tests++;
        if (bus.o_w_alu_oe !== 1'b0 || bus.o_w_alu_carry !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_alu: got oe=%b carry=%b required 0 0",
                     bus.o_w_alu_oe, bus.o_w_alu_carry);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Shared by the directed MUL/DIV/dbz tests: run, compare, check done drops.
    task automatic test_directed(input string nm, input bit op,
                                 input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] ehi, elo;
        logic         edz;
        int           elat, lat;
        bit           aok, bok;
        ref_op(op, a, b, ehi, elo, edz, elat);
        do_op(op, a, b, lat, aok, bok);
        n_tests++;
        if (lat != elat) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d required %0d", nm, lat, elat);
        end
        n_tests++;
        if (bus.o_w_res_hi !== ehi || bus.o_w_res_lo !== elo || bus.o_w_dbz !== edz) begin
            n_fail++;
            $display("FAIL %s_result: got %h_%h dbz=%b required %h_%h dbz=%b",
                     nm, bus.o_w_res_hi, bus.o_w_res_lo, bus.o_w_dbz, ehi, elo, edz);
        end
        n_tests++;
        if (!aok || !bok) begin
            n_fail++;
            $display("FAIL %s_handshake: got alu_ok=%b busy_ok=%b required 1 1",
                     nm, aok, bok);
        end
        @(negedge clk);
        n_tests++;
        if (bus.o_w_done !== 1'b0 || bus.o_w_res_hi !== ehi || bus.o_w_res_lo !== elo) begin
            n_fail++;
            $display("FAIL %s_hold: got done=%b res=%h_%h required 0 %h_%h",
                     nm, bus.o_w_done, bus.o_w_res_hi, bus.o_w_res_lo, ehi, elo);
        end
    endtask

    task automatic test_mul;
        test_directed("mul_7x6", 1'b0, 16'd7, 16'd6);
        test_directed("mul_max", 1'b0, 16'hFFFF, 16'hFFFF);
        test_directed("mul_zero", 1'b0, 16'h0000, 16'h1234);
        test_directed("mul_one", 1'b0, 16'h0001, 16'hFFFF);
    endtask

    task automatic test_div;
        test_directed("div_100_7", 1'b1, 16'd100, 16'd7);
        test_directed("div_8001", 1'b1, 16'h8001, 16'hFFFF);
        test_directed("div_by1", 1'b1, 16'hFFFF, 16'h0001);
        test_directed("div_small", 1'b1, 16'd3, 16'd9);
    endtask

    task automatic test_dbz;
        test_directed("dbz_5", 1'b1, 16'd5, 16'd0);
        test_directed("dbz_clear", 1'b1, 16'd50, 16'd5);
    endtask

    task automatic test_random;
        logic [N-1:0] a, b, ehi, elo;
        logic         edz;
        bit           op, aok, bok;
        int           elat, lat, errs;
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            op = 1'($urandom_range(0, 1));
            a  = N'($urandom);
            case ($urandom_range(0, 3))
                0: b = '0;
                1: b = N'($urandom_range(1, 15));
                default: b = N'($urandom);
            endcase
            ref_op(op, a, b, ehi, elo, edz, elat);
            do_op(op, a, b, lat, aok, bok);
            n_tests++;
            if (lat != elat || bus.o_w_res_hi !== ehi || bus.o_w_res_lo !== elo ||
                bus.o_w_dbz !== edz || !aok || !bok) begin
                n_fail++;
                errs++;
                if (errs < 8)
                    $display("FAIL random_%0d op=%b a=%h b=%h: got %h_%h dbz=%b lat=%0d required %h_%h dbz=%b lat=%0d",
                             i, op, a, b, bus.o_w_res_hi, bus.o_w_res_lo, bus.o_w_dbz,
                             lat, ehi, elo, edz, elat);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_while_busy;
        logic [N-1:0] ehi, elo;
        logic         edz;
        int           elat, lat;
        ref_op(1'b0, 16'h1234, 16'h5678, ehi, elo, edz, elat);
        bus.i_w_start = 1'b1; bus.i_w_op = 1'b0;
        bus.i_w_a = 16'h1234; bus.i_w_b = 16'h5678;
        @(negedge clk);
        bus.i_w_start = 1'b0;
        lat = -1;
        for (int k = 0; k < 64; k++) begin
            if (bus.o_w_done) begin
                lat = k;
                break;
            end
            if (k == 4) begin
                bus.i_w_start = 1'b1; bus.i_w_op = 1'b1;
                bus.i_w_a = 16'd9; bus.i_w_b = 16'd0;
            end else begin
                bus.i_w_start = 1'b0;
            end
            @(negedge clk);
        end
        bus.i_w_start = 1'b0;
        n_tests++;
        if (lat != elat || bus.o_w_res_hi !== ehi || bus.o_w_res_lo !== elo ||
            bus.o_w_dbz !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start_ignored: got %h_%h dbz=%b lat=%0d required %h_%h dbz=0 lat=%0d",
                     bus.o_w_res_hi, bus.o_w_res_lo, bus.o_w_dbz, lat, ehi, elo, elat);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [N-1:0] ehi, elo;
        logic         edz;
        int           elat, lat;
        bit           aok, bok;
        do_op(1'b0, 16'h00FF, 16'h0101, lat, aok, bok);
        // Start again while the first op is in its done cycle.
        ref_op(1'b1, 16'd1000, 16'd33, ehi, elo, edz, elat);
        do_op(1'b1, 16'd1000, 16'd33, lat, aok, bok);
        n_tests++;
        if (lat != elat || bus.o_w_res_hi !== ehi || bus.o_w_res_lo !== elo) begin
            n_fail++;
            $display("FAIL b2b_div: got %h_%h lat=%0d required %h_%h lat=%0d",
                     bus.o_w_res_hi, bus.o_w_res_lo, lat, ehi, elo, elat);
        end
        ref_op(1'b1, 16'hBEEF, 16'd0, ehi, elo, edz, elat);
        do_op(1'b1, 16'hBEEF, 16'd0, lat, aok, bok);
        n_tests++;
        if (lat != elat || bus.o_w_res_hi !== ehi || bus.o_w_res_lo !== elo ||
            bus.o_w_dbz !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_dbz: got %h_%h dbz=%b lat=%0d required %h_%h dbz=1 lat=%0d",
                     bus.o_w_res_hi, bus.o_w_res_lo, bus.o_w_dbz, lat, ehi, elo, elat);
        end
        @(negedge clk);
        n_tests++;
        if (bus.o_w_done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_single_pulse: got done=%b required 0", bus.o_w_done);
        end
    endtask

    task automatic test_reset_mid_op;
        bus.i_w_start = 1'b1; bus.i_w_op = 1'b0;
        bus.i_w_a = 16'hFFFF; bus.i_w_b = 16'hFFFF;
        @(negedge clk);
        bus.i_w_start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.o_w_busy !== 1'b0 || bus.o_w_done !== 1'b0 || bus.o_w_dbz !== 1'b0 ||
            bus.o_w_res_hi !== '0 || bus.o_w_res_lo !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b done=%b dbz=%b res=%h_%h required 0 0 0 0000_0000",
                     bus.o_w_busy, bus.o_w_done, bus.o_w_dbz,
                     bus.o_w_res_hi, bus.o_w_res_lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_directed("after_reset", 1'b0, 16'hABCD, 16'h1357);
    endtask

    initial begin
        test_reset;
        test_mul;
        test_div;
        test_dbz;
        test_random;
        test_start_while_busy;
        test_back_to_back;
        test_reset_mid_op;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
